// File: rtl/regfile_pkg.sv
// Shared constants and bus typedefs for the parametrised register file with scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 20;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned NUM_RD_DEF = 2;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0]            reg_addr_t;
    typedef logic [DATA_W_DEF-1:0]            reg_data_t;
    typedef logic [NUM_RD_DEF*ADDR_W_DEF-1:0] rd_addr_vec_t;
    typedef logic [NUM_RD_DEF*DATA_W_DEF-1:0] rd_data_vec_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: reads, reserve, writeback and pending count.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
) ();

    logic [NUM_RD*ADDR_W-1:0] RegReadAddress;
    logic [NUM_RD*DATA_W-1:0] DataOut;
    logic [NUM_RD-1:0]        BusyOut;
    logic [ADDR_W-1:0]        RegWriteAddress;
    logic [DATA_W-1:0]        WriteData;
    logic                     WriteEnable;
    logic [ADDR_W-1:0]        ReserveAddress;
    logic                     ReserveEnable;
    logic [ADDR_W:0]          PendingCount;

    modport master (
        output RegReadAddress, RegWriteAddress, WriteData, WriteEnable,
               ReserveAddress, ReserveEnable,
        input  DataOut, BusyOut, PendingCount
    );

    modport slave (
        input  RegReadAddress, RegWriteAddress, WriteData, WriteEnable,
               ReserveAddress, ReserveEnable,
        output DataOut, BusyOut, PendingCount
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with reserve-over-clear priority and a registered popcount.
// REGFILE_ZERO_REG_EN: register 0 can never be reserved.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    output logic [(1<<ADDR_W)-1:0] pending,
    output logic [ADDR_W:0]        count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] pending_d;
    logic [ADDR_W:0]  count_d;

    // Reserve is applied after clear so a same-address reserve leaves the bit set.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (clr_en) clr_vec = DEPTH'(1) << clr_addr;
        if (set_en) set_vec = DEPTH'(1) << set_addr;
`ifdef REGFILE_ZERO_REG_EN
        set_vec[0] = 1'b0;
`endif
        pending_d = (pending & ~clr_vec) | set_vec;
        count_d   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + (ADDR_W+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pending_d;
            count   <= count_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-to-read bypass and RAW scoreboard.
// REGFILE_ZERO_REG_EN: register 0 is hardwired to zero and never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
) (
    input logic                 clock,
    input logic                 reset,
    regfile_scoreboard_if.slave rf
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]         pending;
    logic                     wr_ok;
    logic [NUM_RD*DATA_W-1:0] data_out;
    logic [NUM_RD-1:0]        busy_out;
    logic [ADDR_W-1:0]        raddr [NUM_RD];

`ifdef REGFILE_ZERO_REG_EN
    assign wr_ok = rf.WriteEnable && (rf.RegWriteAddress != '0);
`else
    assign wr_ok = rf.WriteEnable;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[rf.RegWriteAddress] <= rf.WriteData;
        end
    end

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .clr_en   (rf.WriteEnable),
        .clr_addr (rf.RegWriteAddress),
        .set_en   (rf.ReserveEnable),
        .set_addr (rf.ReserveAddress),
        .pending  (pending),
        .count    (rf.PendingCount)
    );

    // Read muxes; an in-flight writeback to the same address bypasses the array.
    always_comb begin
        data_out = '0;
        busy_out = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            raddr[i] = rf.RegReadAddress[i*ADDR_W +: ADDR_W];
            data_out[i*DATA_W +: DATA_W] = mem[raddr[i]];
            busy_out[i] = pending[raddr[i]];
            if (wr_ok && !reset && (raddr[i] == rf.RegWriteAddress)) begin
                data_out[i*DATA_W +: DATA_W] = rf.WriteData;
                busy_out[i] = 1'b0;
            end
`ifdef REGFILE_ZERO_REG_EN
            if (raddr[i] == '0) begin
                data_out[i*DATA_W +: DATA_W] = '0;
                busy_out[i] = 1'b0;
            end
`endif
        end
    end

    assign rf.DataOut = data_out;
    assign rf.BusyOut = busy_out;

endmodule
